// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory fetch handshake between the fetch unit (master) and instruction memory (slave).
interface instr_fetch_unit_if #(
  parameter int unsigned IMEM_ADDR_W = 8
) ();
  logic                   imem_req;
  logic [IMEM_ADDR_W-1:0] imem_addr;
  logic                   imem_ack;
  logic [31:0]            imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// MIPS instruction fetch unit: PC, handshaked fetch into IR, next-PC for beq/bne/j/sequential.
// Define IFU_PERF_CNT_EN to add the retired_cnt instruction counter port.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned IMEM_ADDR_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  instr_fetch_unit_if.master        imem,
  output logic [31:0]               instr,
  output logic [5:0]                op,
  output logic                      instr_valid,
  output logic [31:0]               pc,
  input  logic                      exec_done,
  input  logic                      branch,
  input  logic                      branch_ne,
  input  logic                      jump,
  input  logic                      zero
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]               retired_cnt
`endif
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StExec
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        instr_valid_q;
  logic        req_q;

  logic [31:0] pc4;
  logic [31:0] btgt;
  logic [31:0] jtgt;
  logic        take_br;
  logic [31:0] next_pc;

  always_comb begin
    pc4     = pc_q + 32'd4;
    btgt    = pc4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    jtgt    = {pc4[31:28], instr_q[25:0], 2'b00};
    take_br = (branch & zero) | (branch_ne & ~zero);
    next_pc = pc4;
    if (jump) begin
      next_pc = jtgt;
    end else if (take_br) begin
      next_pc = btgt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      req_q         <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StFetch;
          req_q   <= 1'b1;
        end
        StFetch: begin
          if (imem.imem_ack) begin
            instr_q       <= imem.imem_rdata;
            instr_valid_q <= 1'b1;
            req_q         <= 1'b0;
            state_q       <= StExec;
          end
        end
        StExec: begin
          if (exec_done) begin
            pc_q          <= next_pc;
            instr_valid_q <= 1'b0;
            req_q         <= 1'b1;
            state_q       <= StFetch;
          end
        end
        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // Upper PC bits beyond the memory word-address range are simply dropped.
  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q[IMEM_ADDR_W+1:2];
  assign instr          = instr_q;
  assign op             = instr_q[31:26];
  assign instr_valid    = instr_valid_q;
  assign pc             = pc_q;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] retired_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else if (state_q == StExec && exec_done) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, fetch handshake, next-PC selection, wrap, mid-fetch reset.
module tb_instr_fetch_unit;
  logic        clk;
  logic        rst_n;
  logic        rst2_n;
  logic        exec_done;
  logic        branch;
  logic        branch_ne;
  logic        jump;
  logic        zero;
  logic        ack;
  logic        ack2;
  logic [31:0] rdata;

  logic [31:0] instr;
  logic [31:0] pc;
  logic [5:0]  op;
  logic        instr_valid;
  logic [31:0] instr2;
  logic [31:0] pc2;
  logic [5:0]  op2;
  logic        instr_valid2;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] retired;
  logic [31:0] retired2;
`endif

  int checks = 0;
  int errors = 0;

  instr_fetch_unit_if #(.IMEM_ADDR_W(8)) bus ();
  instr_fetch_unit_if #(.IMEM_ADDR_W(8)) bus2 ();

  assign bus.imem_ack    = ack;
  assign bus.imem_rdata  = rdata;
  assign bus2.imem_ack   = ack2;
  assign bus2.imem_rdata = rdata;

  instr_fetch_unit #(
    .RESET_PC    (32'h0000_0100),
    .IMEM_ADDR_W (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (bus.master),
    .instr       (instr),
    .op          (op),
    .instr_valid (instr_valid),
    .pc          (pc),
    .exec_done   (exec_done),
    .branch      (branch),
    .branch_ne   (branch_ne),
    .jump        (jump),
    .zero        (zero)
`ifdef IFU_PERF_CNT_EN
    ,
    .retired_cnt (retired)
`endif
  );

  // Second instance starts high in the address space to exercise the jump-region bits.
  instr_fetch_unit #(
    .RESET_PC    (32'h1000_0008),
    .IMEM_ADDR_W (8)
  ) dut2 (
    .clk         (clk),
    .rst_n       (rst2_n),
    .imem        (bus2.master),
    .instr       (instr2),
    .op          (op2),
    .instr_valid (instr_valid2),
    .pc          (pc2),
    .exec_done   (exec_done),
    .branch      (branch),
    .branch_ne   (branch_ne),
    .jump        (jump),
    .zero        (zero)
`ifdef IFU_PERF_CNT_EN
    ,
    .retired_cnt (retired2)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] w);
    ack   = 1'b1;
    rdata = w;
    tick();
    ack   = 1'b0;
    rdata = 32'hDEAD_BEEF;
  endtask

  task automatic exec(input logic j, input logic b, input logic bn, input logic z);
    jump      = j;
    branch    = b;
    branch_ne = bn;
    zero      = z;
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    jump      = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    zero      = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b1;
    rst2_n    = 1'b1;
    ack       = 1'b0;
    ack2      = 1'b0;
    rdata     = 32'h0;
    exec_done = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    jump      = 1'b0;
    zero      = 1'b0;
    #2;
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    #1;
    chk("rst_pc", pc, 32'h0000_0100);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_req", 32'(bus.imem_req), 32'h0);
    chk("rst_op", 32'(op), 32'h0);
    chk("rst_addr", 32'(bus.imem_addr), 32'h40);
`ifdef IFU_PERF_CNT_EN
    chk("rst_retired", retired, 32'h0);
`endif

    // j with branch also asserted: jump wins, upper nibble from pc+4
    tick();
    rst2_n = 1'b1;
    tick();
    chk("d2_req", 32'(bus2.imem_req), 32'h1);
    chk("d2_addr", 32'(bus2.imem_addr), 32'h02);
    ack2  = 1'b1;
    rdata = 32'h0800_0040;
    tick();
    ack2  = 1'b0;
    rdata = 32'hDEAD_BEEF;
    chk("d2_valid", 32'(instr_valid2), 32'h1);
    chk("d2_instr", instr2, 32'h0800_0040);
    chk("d2_op", 32'(op2), 32'h02);
    exec(1'b1, 1'b1, 1'b0, 1'b1);
    chk("d2_jump_pc", pc2, 32'h1000_0100);
    chk("d2_jump_addr", 32'(bus2.imem_addr), 32'h40);
`ifdef IFU_PERF_CNT_EN
    chk("d2_retired", retired2, 32'h1);
`endif

    // Main instance: idle then fetch with a delayed ack
    rst_n = 1'b1;
    tick();
    chk("fetch_req0", 32'(bus.imem_req), 32'h1);
    chk("fetch_addr", 32'(bus.imem_addr), 32'h40);
    tick();
    chk("fetch_req1", 32'(bus.imem_req), 32'h1);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    chk("fetch_req2", 32'(bus.imem_req), 32'h1);
    chk("fetch_ign_done_pc", pc, 32'h0000_0100);
    chk("fetch_ign_done_valid", 32'(instr_valid), 32'h0);
`ifdef IFU_PERF_CNT_EN
    chk("fetch_ign_done_cnt", retired, 32'h0);
`endif
    fetch(32'h2008_0001);
    chk("addi_valid", 32'(instr_valid), 32'h1);
    chk("addi_instr", instr, 32'h2008_0001);
    chk("addi_op", 32'(op), 32'h08);
    chk("addi_req", 32'(bus.imem_req), 32'h0);
    chk("addi_pc", pc, 32'h0000_0100);

    ack   = 1'b1;
    rdata = 32'h1400_0010;
    tick();
    ack   = 1'b0;
    chk("exec_ign_ack", instr, 32'h2008_0001);
    chk("exec_ign_ack_valid", 32'(instr_valid), 32'h1);

    exec(1'b0, 1'b0, 1'b0, 1'b0);
    chk("seq_pc", pc, 32'h0000_0104);
    chk("seq_valid", 32'(instr_valid), 32'h0);
    chk("seq_req", 32'(bus.imem_req), 32'h1);
    chk("seq_addr", 32'(bus.imem_addr), 32'h41);

    fetch(32'h0800_0080);
    exec(1'b1, 1'b0, 1'b0, 1'b0);
    chk("j200_pc", pc, 32'h0000_0200);

    fetch(32'h1000_FFFF);
    exec(1'b0, 1'b1, 1'b0, 1'b1);
    chk("beq_taken_pc", pc, 32'h0000_0200);
    chk("beq_taken_addr", 32'(bus.imem_addr), 32'h80);

    fetch(32'h1000_FFFF);
    exec(1'b0, 1'b1, 1'b0, 1'b0);
    chk("beq_not_pc", pc, 32'h0000_0204);

    fetch(32'h0800_00C0);
    exec(1'b1, 1'b0, 1'b0, 1'b0);
    chk("j300_pc", pc, 32'h0000_0300);
`ifdef IFU_PERF_CNT_EN
    chk("retired_5", retired, 32'h5);
`endif

    fetch(32'h1400_0010);
    exec(1'b0, 1'b0, 1'b1, 1'b0);
    chk("bne_taken_pc", pc, 32'h0000_0344);
    chk("bne_taken_addr", 32'(bus.imem_addr), 32'hD1);

    fetch(32'h0800_00C0);
    exec(1'b1, 1'b0, 1'b0, 1'b0);
    chk("j300b_pc", pc, 32'h0000_0300);

    fetch(32'h1400_0010);
    exec(1'b0, 1'b0, 1'b1, 1'b1);
    chk("bne_not_pc", pc, 32'h0000_0304);

    fetch(32'h1000_0010);
    exec(1'b0, 1'b1, 1'b1, 1'b0);
    chk("both_flags_pc", pc, 32'h0000_0348);

    fetch(32'h0800_0000);
    exec(1'b1, 1'b0, 1'b0, 1'b0);
    chk("j0_pc", pc, 32'h0000_0000);

    // Backward branch from 0 wraps below zero, then sequential wraps back
    fetch(32'h1000_FFFE);
    exec(1'b0, 1'b1, 1'b0, 1'b1);
    chk("wrap_btgt_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_btgt_addr", 32'(bus.imem_addr), 32'hFF);

    fetch(32'h2008_0001);
    exec(1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrap_seq_pc", pc, 32'h0000_0000);
    chk("wrap_seq_addr", 32'(bus.imem_addr), 32'h00);
`ifdef IFU_PERF_CNT_EN
    chk("retired_12", retired, 32'd12);
`endif

    // Reset while a fetch is outstanding; ack arriving around release must be dropped
    chk("pre_rst_req", 32'(bus.imem_req), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(bus.imem_req), 32'h0);
    chk("mid_rst_pc", pc, 32'h0000_0100);
    ack   = 1'b1;
    rdata = 32'h2008_0001;
    tick();
    rst_n = 1'b1;
    tick();
    ack = 1'b0;
    chk("late_ack_valid", 32'(instr_valid), 32'h0);
    chk("late_ack_instr", instr, 32'h0);
    chk("late_ack_req", 32'(bus.imem_req), 32'h1);
    chk("late_ack_pc", pc, 32'h0000_0100);
`ifdef IFU_PERF_CNT_EN
    chk("late_ack_retired", retired, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
